// File: rtl/lcd_rom_pixel_streamer.sv
// Streams one frame of pixels from a 1-cycle registered-read image ROM to an LCD valid/ready sink.
// Optional build macro LCD_STREAM_LOOP_EN: back-to-back frames while start is held at frame end.
module lcd_rom_pixel_streamer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int PIXEL_COUNT = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_last
);

`ifdef LCD_STREAM_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam int                    CW        = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         COUNT     = CW'(PIXEL_COUNT);
  localparam logic [CW-1:0]         LAST_IDX  = CW'(PIXEL_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIXEL_COUNT - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]         fetch_idx;
  logic                  inflight;
  logic                  inflight_last;
  logic [1:0]            buf_cnt;
  logic [DATA_WIDTH-1:0] buf_data0, buf_data1;
  logic                  buf_last0, buf_last1;
  logic                  wrapped;

  logic       pop, pop_last, restart, end_frame, issue, wrap_now, late_wrap;
  logic [1:0] occupancy;

  // rom_addr always points at the next unissued address; the ROM reads it every cycle,
  // and a read only counts as a fetch in cycles where the credit check lets it issue.
  always_comb begin
    pix_valid = (buf_cnt != 2'd0);
    pix_data  = buf_data0;
    pix_last  = buf_last0 && pix_valid;
    busy      = (state == RUN);
    pop       = pix_valid && pix_ready;
    pop_last  = pop && buf_last0;
    restart   = LOOP_EN && start;
    end_frame = pop_last && !restart;
    occupancy = buf_cnt + {1'b0, inflight} - {1'b0, pop};
    issue     = (state == RUN) && !end_frame && (fetch_idx < COUNT) && (occupancy < 2'd2);
    wrap_now  = issue && (fetch_idx == LAST_IDX) && restart && !wrapped;
    late_wrap = (state == RUN) && !issue && !pop_last && (fetch_idx == COUNT)
                && restart && !wrapped;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (end_frame) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done          <= 1'b0;
      rom_addr      <= '0;
      fetch_idx     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      buf_cnt       <= '0;
      buf_data0     <= '0;
      buf_data1     <= '0;
      buf_last0     <= 1'b0;
      buf_last1     <= 1'b0;
      wrapped       <= 1'b0;
    end else begin
      done <= pop_last;
      if (state == IDLE || end_frame) begin
        // Ending a frame also drops any next-frame prefetch made while start was high.
        rom_addr      <= '0;
        fetch_idx     <= '0;
        inflight      <= 1'b0;
        inflight_last <= 1'b0;
        buf_cnt       <= '0;
        buf_last0     <= 1'b0;
        buf_last1     <= 1'b0;
        wrapped       <= 1'b0;
      end else begin
        inflight      <= issue;
        inflight_last <= issue && (fetch_idx == LAST_IDX);
        if (wrap_now || late_wrap) begin
          fetch_idx <= '0;
          rom_addr  <= '0;
          wrapped   <= 1'b1;
        end else if (issue) begin
          fetch_idx <= fetch_idx + CW'(1);
          if (rom_addr != LAST_ADDR) rom_addr <= rom_addr + ADDR_WIDTH'(1);
        end
        // Continuing past pix_last: the next frame is either already prefetched or starts now.
        if (pop_last) begin
          if (!wrapped) begin
            fetch_idx <= '0;
            rom_addr  <= '0;
          end
          wrapped <= 1'b0;
        end
        case ({inflight, pop})
          2'b10: begin
            if (buf_cnt == 2'd0) begin
              buf_data0 <= rom_data;
              buf_last0 <= inflight_last;
            end else begin
              buf_data1 <= rom_data;
              buf_last1 <= inflight_last;
            end
            buf_cnt <= buf_cnt + 2'd1;
          end
          2'b01: begin
            buf_data0 <= buf_data1;
            buf_last0 <= buf_last1;
            buf_cnt   <= buf_cnt - 2'd1;
          end
          2'b11: begin
            if (buf_cnt == 2'd1) begin
              buf_data0 <= rom_data;
              buf_last0 <= inflight_last;
            end else begin
              buf_data0 <= buf_data1;
              buf_last0 <= buf_last1;
              buf_data1 <= rom_data;
              buf_last1 <= inflight_last;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
